clock_run_ctrl: RTL and testbench

Run/halt/single-step controller for the processor clock. Divides the system clock into the processor clock `clk_out` and emits a one-cycle `cpu_tick` marking each rising edge. Freezes that clock on processor halt codes or debugger halt commands, and resumes it on `ctx` or `dbg_run`. Executes an exact number of processor cycles on `dbg_step`. Sits between the board clock and the processor core, replacing the free-running divider.

---
 rtl/clock_run_ctrl.sv | 136 +++++++++++++
 tb/tb_clock_run_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/clock_run_ctrl.sv
// Run/halt/single-step controller for the divided processor clock.
// Optional step support is built only when CLOCK_RUN_CTRL_STEP_EN is defined.
module clock_run_ctrl #(
  parameter int unsigned DIV    = 2500,
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned STEP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        halt_code,
  input  logic              ctx,
  input  logic              dbg_run,
  input  logic              dbg_halt,
  input  logic              dbg_step,
  input  logic [STEP_W-1:0] step_count,
  output logic              clk_out,
  output logic              cpu_tick,
  output logic              halted,
  output logic [1:0]        state,
  output logic              step_done
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2,
    S_STEP   = 2'd3
  } state_t;

  state_t           cur_state;
  state_t           nxt_state;
  logic [CNT_W-1:0] count;
  logic             clk_q;
  logic             tick_q;
  logic             advance;
  logic             wrap;
  logic             halt_req;
  logic             enter_halted;
  logic             step_load;
  logic             step_fin;

`ifdef CLOCK_RUN_CTRL_STEP_EN
  logic [STEP_W-1:0] remaining;
  logic              done_q;
`else
  logic              unused_step;
  assign unused_step = ^{dbg_step, step_count};
`endif

  assign halt_req     = dbg_halt | halt_code[1];
  assign advance      = (cur_state == S_RUN) || (cur_state == S_STEP) || !clk_q;
  assign wrap         = advance && (count == CNT_W'(DIV));
  assign enter_halted = (nxt_state == S_HALTED) && (cur_state != S_HALTED);

  always_comb begin
    nxt_state = cur_state;
    step_load = 1'b0;
    step_fin  = 1'b0;
    case (cur_state)
      S_RUN: begin
        if (halt_req) nxt_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (clk_q) nxt_state = S_HALTED;
      end
      S_HALTED: begin
        if (dbg_run) begin
          nxt_state = S_RUN;
`ifdef CLOCK_RUN_CTRL_STEP_EN
        end else if (dbg_step && (step_count != '0)) begin
          nxt_state = S_STEP;
          step_load = 1'b1;
`endif
        end else if (ctx && !halt_code[1]) begin
          nxt_state = S_RUN;
        end
      end
      S_STEP: begin
`ifdef CLOCK_RUN_CTRL_STEP_EN
        if (halt_req) begin
          nxt_state = S_DRAIN;
        end else if (tick_q && (remaining == STEP_W'(1))) begin
          nxt_state = S_HALTED;
          step_fin  = 1'b1;
        end
`else
        nxt_state = S_RUN;
`endif
      end
      default: nxt_state = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) cur_state <= S_RUN;
    else       cur_state <= nxt_state;
  end

  // Entering HALTED always re-zeroes the phase so a resume delivers a full
  // high half-period before the falling edge, whichever path led here.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= wrap && !clk_q;
      if (wrap) clk_q <= !clk_q;
      if (enter_halted)  count <= '0;
      else if (wrap)     count <= '0;
      else if (advance)  count <= count + CNT_W'(1);
    end
  end

`ifdef CLOCK_RUN_CTRL_STEP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= step_fin;
      if (step_load)                            remaining <= step_count;
      else if ((cur_state == S_STEP) && tick_q) remaining <= remaining - STEP_W'(1);
    end
  end
  assign step_done = done_q;
`else
  assign step_done = 1'b0;
`endif

  assign clk_out  = clk_q;
  assign cpu_tick = tick_q;
  assign state    = cur_state;
  assign halted   = (cur_state == S_HALTED);

endmodule

// File: tb/tb_clock_run_ctrl.sv
// Directed self-checking bench for clock_run_ctrl with DIV=3 (8-cycle period).
// Step scenarios follow CLOCK_RUN_CTRL_STEP_EN the same way the design does.
module tb_clock_run_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] halt_code;
  logic       ctx;
  logic       dbg_run;
  logic       dbg_halt;
  logic       dbg_step;
  logic [7:0] step_count;
  logic       clk_out;
  logic       cpu_tick;
  logic       halted;
  logic [1:0] state;
  logic       step_done;

  int checks   = 0;
  int failures = 0;
  int tick_cnt = 0;
  int done_cnt = 0;
  int n;
  int t0;
  int d0;
  int bad;

  clock_run_ctrl #(.DIV(3), .CNT_W(4), .STEP_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .halt_code  (halt_code),
    .ctx        (ctx),
    .dbg_run    (dbg_run),
    .dbg_halt   (dbg_halt),
    .dbg_step   (dbg_step),
    .step_count (step_count),
    .clk_out    (clk_out),
    .cpu_tick   (cpu_tick),
    .halted     (halted),
    .state      (state),
    .step_done  (step_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One cycle, sampled on the falling edge; also tallies ticks and step_done.
  task automatic cyc();
    @(negedge clk);
    if (cpu_tick === 1'b1)  tick_cnt++;
    if (step_done === 1'b1) done_cnt++;
  endtask

  // Cycles until the next cpu_tick, bounded at 40.
  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      cyc();
      cycles++;
    end while ((cpu_tick !== 1'b1) && (cycles < 40));
  endtask

  initial begin
    reset = 1'b1; halt_code = 2'b00; ctx = 1'b0;
    dbg_run = 1'b0; dbg_halt = 1'b0; dbg_step = 1'b0; step_count = 8'd0;
    repeat (3) cyc();
    chk("rst_state", state, 0);
    chk("rst_clk", clk_out, 0);
    chk("rst_tick", cpu_tick, 0);
    chk("rst_done", step_done, 0);
    chk("rst_halted", halted, 0);

    // Free run
    reset = 1'b0;
    wait_tick(n);         chk("first_tick", n, 4);
    chk("tick_clk_hi", clk_out, 1);
    repeat (4) cyc();     chk("clk_fall", clk_out, 0);
    wait_tick(n);         chk("tick_after_fall", n, 4);
    wait_tick(n);         chk("period", n, 8);

    // Halt while clk_out low, count 1
    repeat (5) cyc();     chk("pre_halt_clk", clk_out, 0);
    dbg_halt = 1'b1; cyc(); dbg_halt = 1'b0;
    chk("drain1", state, 1);
    cyc();                chk("drain2", state, 1);
    cyc();                chk("drain3", state, 1);
    chk("drain_tick", cpu_tick, 1);
    chk("drain_clk", clk_out, 1);
    cyc();                chk("halt_state", state, 2);
    chk("halt_flag", halted, 1);
    t0 = tick_cnt; bad = 0;
    repeat (20) begin cyc(); if (clk_out !== 1'b1) bad++; end
    chk("halt_hold_clk", bad, 0);
    chk("halt_no_tick", tick_cnt - t0, 0);

`ifdef CLOCK_RUN_CTRL_STEP_EN
    // Step of 3
    step_count = 8'd3; dbg_step = 1'b1; cyc(); dbg_step = 1'b0;
    chk("step_state", state, 3);
    d0 = done_cnt;
    wait_tick(n);         chk("step_t1", n, 8);
    wait_tick(n);         chk("step_t2", n, 8);
    wait_tick(n);         chk("step_t3", n, 8);
    chk("step_done_early", step_done, 0);
    cyc();                chk("step_done", step_done, 1);
    chk("step_halted", halted, 1);
    chk("step_state_end", state, 2);
    cyc();                chk("step_done_pulse", step_done, 0);
    t0 = tick_cnt;
    repeat (20) cyc();
    chk("step_no_extra", tick_cnt - t0, 0);
    chk("step_done_count", done_cnt - d0, 1);
`else
    step_count = 8'd3; dbg_step = 1'b1; cyc(); dbg_step = 1'b0;
    t0 = tick_cnt; d0 = done_cnt;
    repeat (10) cyc();
    chk("nostep_state", state, 2);
    chk("nostep_ticks", tick_cnt - t0, 0);
    chk("nostep_done", done_cnt - d0, 0);
`endif

    // Resume, halt via halt_code, ctx gating
    dbg_run = 1'b1; cyc(); dbg_run = 1'b0;
    chk("run_state", state, 0);
    wait_tick(n);         chk("run_tick", n, 8);
    halt_code = 2'b10; cyc();
    chk("hc_drain", state, 1);
    cyc();                chk("hc_halted", state, 2);
    ctx = 1'b1; repeat (4) cyc();
    chk("ctx_blocked", state, 2);
    chk("ctx_blocked_clk", clk_out, 1);
    halt_code = 2'b00; cyc(); ctx = 1'b0;
    chk("ctx_run", state, 0);
    wait_tick(n);         chk("ctx_tick", n, 8);

`ifdef CLOCK_RUN_CTRL_STEP_EN
    // Aborted step of 5
    dbg_halt = 1'b1; cyc(); dbg_halt = 1'b0;
    chk("ab_drain0", state, 1);
    cyc();                chk("ab_halted0", state, 2);
    step_count = 8'd5; dbg_step = 1'b1; cyc(); dbg_step = 1'b0;
    chk("ab_step", state, 3);
    t0 = tick_cnt; d0 = done_cnt;
    wait_tick(n);         chk("ab_t1", n, 8);
    wait_tick(n);         chk("ab_t2", n, 8);
    dbg_halt = 1'b1; cyc(); dbg_halt = 1'b0;
    chk("ab_drain", state, 1);
    cyc();                chk("ab_halted", state, 2);
    repeat (20) cyc();
    chk("ab_ticks", tick_cnt - t0, 2);
    chk("ab_no_done", done_cnt - d0, 0);

    // Reset mid-step
    dbg_step = 1'b1; cyc(); dbg_step = 1'b0;
    chk("rs_step", state, 3);
    repeat (5) cyc();
`else
    repeat (5) cyc();
`endif
    chk("rs_pre_clk", clk_out, 0);
    reset = 1'b1; cyc();
    chk("rs_state", state, 0);
    chk("rs_clk", clk_out, 0);
    chk("rs_done", step_done, 0);
    chk("rs_tick", cpu_tick, 0);
    reset = 1'b0;
    wait_tick(n);         chk("rs_first_tick", n, 4);
    wait_tick(n);         chk("rs_period", n, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
